// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage RISC-V pipeline.
// Turns hazard/branch/memory/halt requests into pipeline-register write
// enables and flushes, and runs the multi-cycle flush, memory-wait and
// halt-drain sequences.
//
// Optional build macro: PIPE_CTRL_PERF_CNT_EN adds the stall_cycles and
// flush_cycles performance counters.
//
// Handshake note: there is no valid/ready pair here. mem_req/mem_ready act
// as a level request/complete pair. The MEM stage holds mem_req until the
// cycle in which mem_ready=1. While mem_req=1 and mem_ready=0, the whole
// pipeline freezes. mem_req=1 with mem_ready=1 completes in that cycle
// without a wait cycle.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        halted,
  output logic        mem_err,
  output logic [2:0]  state_dbg
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_FLUSH    = 3'd1,
    S_DRAIN    = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_HALTED   = 3'd4
  } state_t;

  state_t     state, ret_state;
  logic [2:0] flush_cnt, drain_cnt;
  logic [7:0] wait_cnt;
  logic       mem_err_q;

  state_t     nxt_state, nxt_ret_state, eff_state;
  logic [2:0] nxt_flush_cnt, nxt_drain_cnt;
  logic [7:0] nxt_wait_cnt;
  logic       nxt_mem_err;

  // Packed enables: {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we}
  logic [5:0] ctl;

  localparam logic [5:0] CTL_FREEZE   = 6'b00_00_00;
  localparam logic [5:0] CTL_NORMAL   = 6'b11_00_11;
  localparam logic [5:0] CTL_RESET    = 6'b00_11_00;
  localparam logic [5:0] CTL_BRANCH   = 6'b11_11_11;
  localparam logic [5:0] CTL_STALL    = 6'b00_01_11;
  localparam logic [5:0] CTL_HALT_ACC = 6'b01_10_11;
  localparam logic [5:0] CTL_FLUSH    = 6'b11_10_11;
  localparam logic [5:0] CTL_DRAIN    = 6'b00_11_11;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);
  localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

  // Decode the current cycle and compute the next state and counters.
  always_comb begin
    ctl           = CTL_FREEZE;
    eff_state     = state;
    nxt_state     = state;
    nxt_ret_state = ret_state;
    nxt_flush_cnt = flush_cnt;
    nxt_drain_cnt = drain_cnt;
    nxt_wait_cnt  = wait_cnt;
    nxt_mem_err   = mem_err_q;

    if (rst) begin
      ctl = CTL_RESET;
    end else if (state == S_HALTED) begin
      ctl = CTL_FREEZE;
    end else if (state == S_MEM_WAIT && !mem_ready) begin
      // Still waiting on data memory. Give up after the timeout budget.
      ctl = CTL_FREEZE;
      if (wait_cnt == WAIT_LAST) begin
        nxt_mem_err = 1'b1;
        nxt_state   = S_HALTED;
      end else begin
        nxt_wait_cnt = wait_cnt + 8'd1;
      end
    end else if (state != S_MEM_WAIT && mem_req && !mem_ready) begin
      // New memory stall: freeze now and remember where to resume.
      ctl           = CTL_FREEZE;
      nxt_ret_state = state;
      nxt_wait_cnt  = 8'd0;
      nxt_state     = S_MEM_WAIT;
    end else begin
      // On the resume cycle, decode as the saved state with freeze cleared.
      if (state == S_MEM_WAIT) begin
        eff_state = ret_state;
      end
      nxt_state = eff_state;
      case (eff_state)
        S_RUN: begin
          if (branch_taken) begin
            ctl = CTL_BRANCH;
            if (FLUSH_CYCLES > 1) begin
              nxt_state     = S_FLUSH;
              nxt_flush_cnt = FLUSH_INIT;
            end
          end else if (hazard_stall) begin
            ctl = CTL_STALL;
          end else if (halt_req) begin
            ctl           = CTL_HALT_ACC;
            nxt_state     = S_DRAIN;
            nxt_drain_cnt = DRAIN_INIT;
          end else begin
            ctl = CTL_NORMAL;
          end
        end
        S_FLUSH: begin
          ctl           = CTL_FLUSH;
          nxt_flush_cnt = flush_cnt - 3'd1;
          if (flush_cnt == 3'd1) begin
            nxt_state = S_RUN;
          end
        end
        S_DRAIN: begin
          ctl           = CTL_DRAIN;
          nxt_drain_cnt = drain_cnt - 3'd1;
          if (drain_cnt == 3'd1) begin
            nxt_state = S_HALTED;
          end
        end
        default: begin
          ctl = CTL_FREEZE;
        end
      endcase
    end
  end

  // State, saved return state, sequence counters and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      ret_state <= S_RUN;
      flush_cnt <= 3'd0;
      drain_cnt <= 3'd0;
      wait_cnt  <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= nxt_state;
      ret_state <= nxt_ret_state;
      flush_cnt <= nxt_flush_cnt;
      drain_cnt <= nxt_drain_cnt;
      wait_cnt  <= nxt_wait_cnt;
      mem_err_q <= nxt_mem_err;
    end
  end

  // Fan the decoded control word out to the ports.
  always_comb begin
    {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we} = ctl;
    halted    = !rst && (state == S_HALTED);
    mem_err   = !rst && mem_err_q;
    state_dbg = state;
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  // Count stalled-fetch cycles and IF/ID flush cycles; both wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_cycles <= 32'd0;
    end else begin
      if (!pc_we && !halted) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (if_id_flush) begin
        flush_cycles <= flush_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table, hand-written timeout/reset sequences,
// and randomized stimulus against a count-based reference model.
module tb_pipe_ctrl;

  localparam int FC = 3;
  localparam int MT = 16;
  localparam int DC = 3;

  // Expected-output words: {pc_we, if_id_we, if_id_flush, id_ex_flush,
  //                         ex_mem_we, mem_wb_we, halted, mem_err}
  localparam logic [7:0] E_RST   = 8'b0011_0000;
  localparam logic [7:0] E_NORM  = 8'b1100_1100;
  localparam logic [7:0] E_STALL = 8'b0001_1100;
  localparam logic [7:0] E_BR    = 8'b1111_1100;
  localparam logic [7:0] E_FLSH  = 8'b1110_1100;
  localparam logic [7:0] E_FRZ   = 8'b0000_0000;
  localparam logic [7:0] E_HACC  = 8'b0110_1100;
  localparam logic [7:0] E_DRN   = 8'b0011_1100;
  localparam logic [7:0] E_HLT   = 8'b0000_0010;
  localparam logic [7:0] E_HERR  = 8'b0000_0011;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hazard_stall, branch_taken, mem_req, mem_ready, halt_req;
  logic pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we;
  logic halted, mem_err;
  logic [2:0] state_dbg;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  pipe_ctrl #(
    .FLUSH_CYCLES(FC),
    .MEM_TIMEOUT (MT),
    .DRAIN_CYCLES(DC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hazard_stall(hazard_stall),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .halt_req    (halt_req),
    .pc_we       (pc_we),
    .if_id_we    (if_id_we),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .ex_mem_we   (ex_mem_we),
    .mem_wb_we   (mem_wb_we),
    .halted      (halted),
    .mem_err     (mem_err),
    .state_dbg   (state_dbg)
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles)
`endif
  );

  logic [7:0] obs;
  assign obs = {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we, halted, mem_err};

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs {rst,hs,bt,mq,mr,hr}, compare at the falling edge.
  task automatic step(input logic [5:0] in, input logic [7:0] exp, input string name);
    {rst, hazard_stall, branch_taken, mem_req, mem_ready, halt_req} = in;
    @(negedge clk);
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Tracks remaining flush/drain cycles and the length of the current
  // memory stall rather than a state machine.
  bit m_dead, m_err;
  int m_flush_left, m_drain_left, m_stuck_run;

  task automatic model_step(input logic [5:0] in, output logic [7:0] exp);
    bit r, hs, bt, mq, mr, hr, stuck;
    {r, hs, bt, mq, mr, hr} = in;
    if (r) begin
      exp = E_RST;
      m_dead = 0; m_err = 0; m_flush_left = 0; m_drain_left = 0; m_stuck_run = 0;
      return;
    end
    if (m_dead) begin
      exp = {6'b000000, 1'b1, m_err};
      return;
    end
    stuck = (m_stuck_run > 0) ? !mr : (mq && !mr);
    if (stuck) begin
      exp = E_FRZ;
      m_stuck_run++;
      // entry cycle plus MT counted wait cycles
      if (m_stuck_run == MT + 1) begin
        m_err = 1;
        m_dead = 1;
        m_stuck_run = 0;
      end
      return;
    end
    m_stuck_run = 0;
    if (m_flush_left > 0) begin
      exp = E_FLSH;
      m_flush_left--;
    end else if (m_drain_left > 0) begin
      exp = E_DRN;
      m_drain_left--;
      if (m_drain_left == 0) m_dead = 1;
    end else if (bt) begin
      exp = E_BR;
      m_flush_left = FC - 1;
    end else if (hs) begin
      exp = E_STALL;
    end else if (hr) begin
      exp = E_HACC;
      m_drain_left = DC;
    end else begin
      exp = E_NORM;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0] in;   // {rst, hs, bt, mq, mr, hr}
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[28];

  initial begin
    logic [7:0] e;
    logic [5:0] in;
    int p_ready;
    int dead_run;

    vecs[0]  = '{6'b100000, E_RST};    // reset held
    vecs[1]  = '{6'b100000, E_RST};
    vecs[2]  = '{6'b000000, E_NORM};   // released, idle
    vecs[3]  = '{6'b010000, E_STALL};  // load-use stall
    vecs[4]  = '{6'b000000, E_NORM};
    vecs[5]  = '{6'b001000, E_BR};     // branch: flush 1 of 3
    vecs[6]  = '{6'b000000, E_FLSH};   // flush 2 of 3
    vecs[7]  = '{6'b010001, E_FLSH};   // flush 3 of 3, stall/halt ignored
    vecs[8]  = '{6'b000000, E_NORM};
    vecs[9]  = '{6'b001100, E_FRZ};    // mem wait with branch held: 4 freeze
    vecs[10] = '{6'b001100, E_FRZ};
    vecs[11] = '{6'b001100, E_FRZ};
    vecs[12] = '{6'b001100, E_FRZ};
    vecs[13] = '{6'b001110, E_BR};     // resume acts on the held branch
    vecs[14] = '{6'b000000, E_FLSH};
    vecs[15] = '{6'b000100, E_FRZ};    // freeze inside FLUSH
    vecs[16] = '{6'b000110, E_FLSH};   // resume FLUSH, last flush cycle
    vecs[17] = '{6'b000000, E_NORM};
    vecs[18] = '{6'b000110, E_NORM};   // req+ready same cycle: no freeze
    vecs[19] = '{6'b000001, E_HACC};   // halt accepted
    vecs[20] = '{6'b011000, E_DRN};    // drain 1, branch/stall ignored
    vecs[21] = '{6'b000100, E_FRZ};    // freeze inside DRAIN
    vecs[22] = '{6'b000110, E_DRN};    // drain 2
    vecs[23] = '{6'b000000, E_DRN};    // drain 3
    vecs[24] = '{6'b001100, E_HLT};    // halted ignores freeze/branch
    vecs[25] = '{6'b000001, E_HLT};
    vecs[26] = '{6'b100000, E_RST};    // reset out of HALTED
    vecs[27] = '{6'b000000, E_NORM};

    {rst, hazard_stall, branch_taken, mem_req, mem_ready, halt_req} = 6'b100000;

    for (int i = 0; i < 28; i++) begin
      step(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Memory timeout: entry freeze + MT wait cycles, then halted with error.
    for (int i = 0; i < MT + 1; i++) begin
      step(6'b000100, E_FRZ, $sformatf("tmo_wait%0d", i));
    end
    step(6'b000100, E_HERR, "tmo_halt");
    step(6'b000110, E_HERR, "tmo_sticky_ready");
    step(6'b001001, E_HERR, "tmo_sticky_inputs");
    step(6'b100000, E_RST, "tmo_reset");
    step(6'b000000, E_NORM, "tmo_after_reset");

    // Reset in the middle of FLUSH returns straight to RUN.
    step(6'b001000, E_BR, "midflush_branch");
    step(6'b100000, E_RST, "midflush_reset");
    step(6'b000000, E_NORM, "midflush_run");

    // Reset in the middle of MEM_WAIT and DRAIN.
    step(6'b000100, E_FRZ, "midwait_freeze");
    step(6'b100100, E_RST, "midwait_reset");
    step(6'b000000, E_NORM, "midwait_run");
    step(6'b000001, E_HACC, "middrain_halt");
    step(6'b100000, E_RST, "middrain_reset");
    step(6'b000000, E_NORM, "middrain_run");

    // ---------------- randomized phase ----------------
    model_step(6'b100000, e);
    step(6'b100000, E_RST, "rand_init_reset");
    p_ready = 50;
    dead_run = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) p_ready = (p_ready == 50) ? 5 : 50;
      in[5] = ($urandom_range(0, 199) == 0) || (dead_run > 4);
      in[4] = ($urandom_range(0, 99) < 20);
      in[3] = ($urandom_range(0, 99) < 15);
      in[2] = ($urandom_range(0, 99) < 30);
      in[1] = ($urandom_range(0, 99) < p_ready);
      in[0] = ($urandom_range(0, 99) < 3);
      model_step(in, e);
      exp_q.push_back(e);
      {rst, hazard_stall, branch_taken, mem_req, mem_ready, halt_req} = in;
      @(negedge clk);
      check($sformatf("rand%0d", i), exp_q.pop_front());
      @(posedge clk);
      #1;
      dead_run = m_dead ? dead_run + 1 : 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
